// File: rtl/usb_reg_master.sv
// Purpose : initiator for the register bus; turns cmd bursts into ALE/CE/RD/WR strobe sequences.
// Latency : ADDR one cycle after accept; read byte appears pSTROBE_CYCLES+1 cycles after RDn falls; done in END.
// Backpr. : cmd_ready only in IDLE; write bursts hold in GAP while wdata_valid=0; rdata has no backpressure.
//
// Ports:
//   clk_usb, reset_n                 clock, synchronous active-low reset
//   cmd_valid/cmd_ready              command handshake (cmd_write, cmd_addr, cmd_len = bytes-1)
//   wdata/wdata_valid/wdata_ready    write byte stream, consumed on the GAP->STROBE cycle
//   rdata/rdata_valid                read byte stream, one-cycle pulse per byte
//   done                             one-cycle pulse in the END state
//   USB_*                            registered bus outputs and bus read data input
module usb_reg_master #(
    parameter int unsigned pSTROBE_CYCLES = 2,  // 1..15
    parameter int unsigned pGAP_CYCLES    = 1   // 1..15
) (
    input  logic       clk_usb,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_len,
    input  logic [7:0] wdata,
    input  logic       wdata_valid,
    output logic       wdata_ready,
    output logic [7:0] rdata,
    output logic       rdata_valid,
    output logic       done,
    output logic [7:0] USB_Addr,
    output logic [7:0] USB_Data_out,
    output logic       USB_Data_oe,
    input  logic [7:0] USB_Data_in,
    output logic       USB_RDn,
    output logic       USB_WRn,
    output logic       USB_CEn,
    output logic       USB_ALEn
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_STROBE,
        ST_GAP,
        ST_END
    } state_t;

    localparam logic [3:0] STB_LAST = 4'(pSTROBE_CYCLES - 1);
    localparam logic [3:0] GAP_LAST = 4'(pGAP_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] phase_q, phase_d;   // cycles spent in the current STROBE/GAP
    logic [8:0] bytes_q, bytes_d;   // bytes still to transfer; 9 bits so 256 fits
    logic       write_q;
    logic       accept;
    logic       sample_last;
    logic       samp_vld_q;
    logic [7:0] samp_q;

    // ---------------- state register ----------------
    always_ff @(posedge clk_usb) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            phase_q <= 4'd0;
            bytes_q <= 9'd0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bytes_q <= bytes_d;
            if (accept) begin
                write_q <= cmd_write;
            end
        end
    end

    // ---------------- next state / handshake outputs ----------------
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        bytes_d     = bytes_q;
        cmd_ready   = 1'b0;
        wdata_ready = 1'b0;
        done        = 1'b0;
        accept      = 1'b0;
        sample_last = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = ST_ADDR;
                    phase_d = 4'd0;
                    bytes_d = {1'b0, cmd_len} + 9'd1;
                end
            end
            ST_ADDR: begin
                state_d = ST_GAP;
                phase_d = 4'd0;
            end
            ST_GAP: begin
                if (phase_q != GAP_LAST) begin
                    phase_d = phase_q + 4'd1;
                end else if (bytes_q == 9'd0) begin
                    state_d = ST_END;
                end else if (!write_q || wdata_valid) begin
                    // A write with no data parks here, strobes high, until data shows up.
                    state_d     = ST_STROBE;
                    phase_d     = 4'd0;
                    bytes_d     = bytes_q - 9'd1;
                    wdata_ready = write_q;
                end
            end
            ST_STROBE: begin
                if (phase_q == STB_LAST) begin
                    state_d     = ST_GAP;
                    phase_d     = 4'd0;
                    sample_last = !write_q;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            ST_END: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------- registered bus outputs ----------------
    // Decoded from state_d so each flop lines up exactly with the state it belongs to.
    always_ff @(posedge clk_usb) begin
        if (!reset_n) begin
            USB_ALEn     <= 1'b1;
            USB_CEn      <= 1'b1;
            USB_RDn      <= 1'b1;
            USB_WRn      <= 1'b1;
            USB_Data_oe  <= 1'b0;
            USB_Addr     <= 8'h00;
            USB_Data_out <= 8'h00;
        end else begin
            USB_ALEn <= (state_d != ST_ADDR);
            USB_CEn  <= !((state_d == ST_ADDR) || (state_d == ST_STROBE) || (state_d == ST_GAP));
            USB_RDn  <= !((state_d == ST_STROBE) && !write_q);
            USB_WRn  <= !((state_d == ST_STROBE) && write_q);
            if (accept) begin
                USB_Addr <= cmd_addr;
            end
            if (wdata_ready) begin
                USB_Data_out <= wdata;
            end
            // Driver stays on through the GAP after a write strobe, including an underflow stall.
            if (wdata_ready) begin
                USB_Data_oe <= 1'b1;
            end else if ((state_d == ST_END) || (state_d == ST_IDLE)) begin
                USB_Data_oe <= 1'b0;
            end
        end
    end

    // ---------------- read return path ----------------
    // Bus data is captured at the close of the last RDn-low cycle, then presented one cycle later.
    always_ff @(posedge clk_usb) begin
        if (!reset_n) begin
            samp_vld_q  <= 1'b0;
            samp_q      <= 8'h00;
            rdata_valid <= 1'b0;
            rdata       <= 8'h00;
        end else begin
            samp_vld_q <= sample_last;
            if (sample_last) begin
                samp_q <= USB_Data_in;
            end
            rdata_valid <= samp_vld_q;
            if (samp_vld_q) begin
                rdata <= samp_q;
            end
        end
    end

endmodule

// File: tb/tb_usb_reg_master.sv
module tb_usb_reg_master;

    localparam int S = 2;
    localparam int G = 1;

    logic       clk_usb = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [7:0] cmd_addr = 8'h00;
    logic [7:0] cmd_len = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic       wdata_valid = 1'b0;
    logic       wdata_ready;
    logic [7:0] rdata;
    logic       rdata_valid;
    logic       done;
    logic [7:0] USB_Addr;
    logic [7:0] USB_Data_out;
    logic       USB_Data_oe;
    logic [7:0] USB_Data_in = 8'h00;
    logic       USB_RDn, USB_WRn, USB_CEn, USB_ALEn;

    always #5 clk_usb = ~clk_usb;

    usb_reg_master #(.pSTROBE_CYCLES(S), .pGAP_CYCLES(G)) dut (
        .clk_usb(clk_usb), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .rdata(rdata), .rdata_valid(rdata_valid), .done(done),
        .USB_Addr(USB_Addr), .USB_Data_out(USB_Data_out), .USB_Data_oe(USB_Data_oe),
        .USB_Data_in(USB_Data_in), .USB_RDn(USB_RDn), .USB_WRn(USB_WRn),
        .USB_CEn(USB_CEn), .USB_ALEn(USB_ALEn)
    );

    // ---------------- expected per-cycle bus picture ----------------
    typedef struct {
        bit       rdy, ale_n, ce_n, rd_n, wr_n, oe, wrdy, done;
        bit [7:0] addr, dout;
    } exp_t;

    exp_t     exp_q [int];
    bit [7:0] exp_rd [int];
    int       cyc = 0;
    int       vectors = 0;
    int       miscompares = 0;

    bit [7:0] m_addr = 8'h00;   // model of the latched address register
    bit [7:0] m_dout = 8'h00;   // model of the last written byte on the bus

    // knobs for the stimulus
    bit       nxt_vld = 0;
    bit       nxt_write = 0;
    bit [7:0] nxt_addr = 0, nxt_len = 0;
    int       stall_rand_max = 0, stall_fix_byte = -1, stall_fix_n = 0, rst_byte = -1;
    bit       rd_fix = 0, wd_fix = 0;
    bit [7:0] wd_val = 0;

    always @(posedge clk_usb) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, want);
        end
    endtask

    function automatic exp_t mk(input bit rdy, input bit ale_n, input bit ce_n, input bit rd_n,
                                input bit wr_n, input bit oe, input bit wrdy, input bit dn);
        exp_t r;
        r.rdy = rdy; r.ale_n = ale_n; r.ce_n = ce_n; r.rd_n = rd_n; r.wr_n = wr_n;
        r.oe = oe; r.wrdy = wrdy; r.done = dn; r.addr = m_addr; r.dout = m_dout;
        return r;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk_usb) begin : compare
        exp_t e;
        if (exp_q.exists(cyc)) begin
            e = exp_q[cyc];
            chk("cmd_ready",   32'(cmd_ready),    32'(e.rdy));
            chk("ALEn",        32'(USB_ALEn),     32'(e.ale_n));
            chk("CEn",         32'(USB_CEn),      32'(e.ce_n));
            chk("RDn",         32'(USB_RDn),      32'(e.rd_n));
            chk("WRn",         32'(USB_WRn),      32'(e.wr_n));
            chk("Data_oe",     32'(USB_Data_oe),  32'(e.oe));
            chk("wdata_ready", 32'(wdata_ready),  32'(e.wrdy));
            chk("done",        32'(done),         32'(e.done));
            chk("Addr",        32'(USB_Addr),     32'(e.addr));
            chk("Data_out",    32'(USB_Data_out), 32'(e.dout));
            chk("rdata_valid", 32'(rdata_valid),  32'(exp_rd.exists(cyc)));
            if (exp_rd.exists(cyc)) chk("rdata", 32'(rdata), 32'(exp_rd[cyc]));
            chk("rd_wr_overlap", 32'(USB_RDn | USB_WRn), 32'd1);
            chk("strobe_in_ale", 32'(USB_ALEn | (USB_RDn & USB_WRn)), 32'd1);
            exp_q.delete(cyc);
        end
    end

    // ---------------- event monitor for the literal checks ----------------
    int          wr_fall, rd_fall, wr_low, done_cnt, done_cyc, ale_cyc, oe_cnt, idle_ce;
    bit          ale_seen;
    logic        prev_wr = 1'b1, prev_rd = 1'b1;
    logic [7:0]  rv_q [$];

    always @(negedge clk_usb) begin
        if (prev_wr === 1'b1 && USB_WRn === 1'b0) wr_fall++;
        if (prev_rd === 1'b1 && USB_RDn === 1'b0) rd_fall++;
        if (USB_WRn === 1'b0) wr_low++;
        if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
        if (USB_ALEn === 1'b0 && !ale_seen) begin ale_seen = 1; ale_cyc = cyc; end
        if (USB_Data_oe === 1'b1) oe_cnt++;
        if (USB_CEn === 1'b0 && USB_ALEn === 1'b1 && USB_RDn === 1'b1 && USB_WRn === 1'b1) idle_ce++;
        if (rdata_valid === 1'b1) rv_q.push_back(rdata);
        prev_wr = USB_WRn;
        prev_rd = USB_RDn;
    end

    task automatic clr_mon();
        wr_fall = 0; rd_fall = 0; wr_low = 0; done_cnt = 0; done_cyc = 0;
        ale_cyc = 0; oe_cnt = 0; idle_ce = 0; ale_seen = 0;
        rv_q.delete();
    endtask

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk_usb);
        #1;
    endtask

    task automatic drive_rand();
        reset_n     = 1'b1;
        cmd_valid   = nxt_vld;
        cmd_write   = nxt_vld ? nxt_write : 1'($urandom);
        cmd_addr    = nxt_vld ? nxt_addr  : 8'($urandom);
        cmd_len     = nxt_vld ? nxt_len   : 8'($urandom);
        wdata       = 8'($urandom);
        wdata_valid = 1'($urandom);
        USB_Data_in = 8'($urandom);
    endtask

    task automatic idle_cycle();
        tick();
        drive_rand();
        exp_q[cyc] = mk(1, 1, 1, 1, 1, 0, 0, 0);
    endtask

    // One burst laid out cycle by cycle from the protocol rules.
    task automatic run_cmd(input bit wr, input bit [7:0] a, input bit [7:0] len);
        bit oe_m;
        int stall;
        tick();
        drive_rand();
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = len;
        exp_q[cyc] = mk(1, 1, 1, 1, 1, 0, 0, 0);
        m_addr = a;
        tick();
        drive_rand();
        exp_q[cyc] = mk(0, 0, 0, 1, 1, 0, 0, 0);
        oe_m = 0;
        for (int b = 0; b <= int'(len); b++) begin
            stall = 0;
            if (wr) stall = (b == stall_fix_byte) ? stall_fix_n : $urandom_range(stall_rand_max, 0);
            for (int g = 0; g < G - 1 + stall; g++) begin
                tick();
                drive_rand();
                if (g >= G - 1) wdata_valid = 1'b0;
                exp_q[cyc] = mk(0, 1, 0, 1, 1, oe_m, 0, 0);
            end
            tick();
            drive_rand();
            if (wr) begin
                wdata_valid = 1'b1;
                if (wd_fix) wdata = 8'(wd_val + b);
            end
            exp_q[cyc] = mk(0, 1, 0, 1, 1, oe_m, wr, 0);
            if (wr) m_dout = wdata;
            for (int s = 0; s < S; s++) begin
                tick();
                drive_rand();
                if (rd_fix) USB_Data_in = 8'(b + 1);
                exp_q[cyc] = mk(0, 1, 0, wr, !wr, wr, 0, 0);
                if (!wr && s == S - 1) exp_rd[cyc + 2] = USB_Data_in;
                if (b == rst_byte && s == 0) begin
                    reset_n = 1'b0;
                    m_addr = 8'h00;
                    m_dout = 8'h00;
                    return;
                end
            end
            oe_m = wr;
        end
        for (int g = 0; g < G; g++) begin
            tick();
            drive_rand();
            exp_q[cyc] = mk(0, 1, 0, 1, 1, oe_m, 0, 0);
        end
        tick();
        drive_rand();
        exp_q[cyc] = mk(0, 1, 1, 1, 1, 0, 0, 1);
    endtask

    initial begin
        // reset: outputs at their reset values from the first edge on
        for (int i = 0; i < 3; i++) begin
            tick();
            drive_rand();
            reset_n = 1'b0;
            exp_q[cyc] = mk(1, 1, 1, 1, 1, 0, 0, 0);
        end
        idle_cycle();
        idle_cycle();
        chk("reset_addr", 32'(USB_Addr), 32'h00);
        chk("reset_dout", 32'(USB_Data_out), 32'h00);

        // single write
        clr_mon();
        wd_fix = 1; wd_val = 8'h5C;
        run_cmd(1, 8'h3A, 8'd0);
        wd_fix = 0;
        idle_cycle(); idle_cycle();
        chk("sw_wr_pulses", wr_fall, 1);
        chk("sw_wr_low_cycles", wr_low, 2);
        chk("sw_done_after_addr", done_cyc - ale_cyc, 5);
        chk("sw_dout", 32'(USB_Data_out), 32'h5C);
        chk("sw_addr", 32'(USB_Addr), 32'h3A);

        // read burst with known bus data
        clr_mon();
        rd_fix = 1;
        run_cmd(0, 8'h10, 8'd3);
        rd_fix = 0;
        idle_cycle(); idle_cycle();
        chk("rb_rd_pulses", rd_fall, 4);
        chk("rb_nbytes", rv_q.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("rb_byte%0d", i), (i < rv_q.size()) ? 32'(rv_q[i]) : 32'hFFFF, i + 1);
        chk("rb_oe_cycles", oe_cnt, 0);
        chk("rb_done", done_cnt, 1);

        // write underflow: second byte withheld 10 cycles
        clr_mon();
        stall_fix_byte = 1; stall_fix_n = 10;
        run_cmd(1, 8'h21, 8'd1);
        stall_fix_byte = -1;
        idle_cycle(); idle_cycle();
        chk("uf_wr_pulses", wr_fall, 2);
        chk("uf_gap_cycles", idle_ce, 13);
        chk("uf_done", done_cnt, 1);

        // maximum burst
        clr_mon();
        run_cmd(1, 8'hC3, 8'd255);
        idle_cycle(); idle_cycle();
        chk("max_wr_pulses", wr_fall, 256);
        chk("max_done", done_cnt, 1);
        chk("max_duration", done_cyc - ale_cyc, 770);

        // reset during 2nd strobe of a 4-byte read
        clr_mon();
        rst_byte = 1;
        run_cmd(0, 8'h55, 8'd3);
        rst_byte = -1;
        idle_cycle(); idle_cycle(); idle_cycle();
        chk("rst_rd_pulses", rd_fall, 2);
        chk("rst_nbytes", rv_q.size(), 1);
        chk("rst_done", done_cnt, 0);

        // command held valid through a busy burst
        clr_mon();
        nxt_vld = 1; nxt_write = 0; nxt_addr = 8'h77; nxt_len = 8'd2;
        run_cmd(1, 8'h66, 8'd1);
        nxt_vld = 0;
        run_cmd(0, 8'h77, 8'd2);
        idle_cycle(); idle_cycle();
        chk("busy_done", done_cnt, 2);
        chk("busy_wr_pulses", wr_fall, 2);
        chk("busy_rd_pulses", rd_fall, 3);

        // randomized traffic
        stall_rand_max = 3;
        for (int n = 0; n < 40; n++) begin
            int nidle;
            nidle = $urandom_range(3, 0);
            for (int i = 0; i < nidle; i++) idle_cycle();
            run_cmd(1'($urandom), 8'($urandom),
                    ($urandom_range(7, 0) == 0) ? 8'($urandom_range(30, 8)) : 8'($urandom_range(7, 0)));
        end
        idle_cycle(); idle_cycle(); idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/usb_reg_master.md
USB_REG_MASTER -- requirements
Module: usb_reg_master

Interface
REQ-001 Parameter pSTROBE_CYCLES, default 2: number of clk_usb cycles each RDn/WRn strobe is held low; legal range 1..15.
REQ-002 Parameter pGAP_CYCLES, default 1: number of clk_usb cycles strobes are held high between bytes; legal range 1..15.
REQ-003 clk_usb  in  1  single clock; all logic on its rising edge.
REQ-004 reset_n  in  1  synchronous active-low reset.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  block is idle and accepts a command.
REQ-007 cmd_write  in  1  1 = write burst, 0 = read burst.
REQ-008 cmd_addr  in  8  register address.
REQ-009 cmd_len  in  8  byte count minus one, so 0 means 1 byte and 255 means 256 bytes.
REQ-010 wdata  in  8  write byte.
REQ-011 wdata_valid  in  1  wdata is available.
REQ-012 wdata_ready  out  1  wdata is consumed this cycle.
REQ-013 rdata  out  8  read byte.
REQ-014 rdata_valid  out  1  one-cycle pulse; rdata is valid. There is no backpressure.
REQ-015 done  out  1  one-cycle pulse at the end of a burst.
REQ-016 USB_Addr  out  8  bus address.
REQ-017 USB_Data_out  out  8  bus write data.
REQ-018 USB_Data_oe  out  1  bus data driver enable.
REQ-019 USB_Data_in  in  8  bus read data.
REQ-020 USB_RDn, USB_WRn, USB_CEn, USB_ALEn  out  1 each  active-low bus strobes.

Function
REQ-021 The block is the initiator for the register-bus responder. All bus outputs shall be registered.
REQ-022 The state machine has five states.
- IDLE: cmd_ready=1; all strobes high; USB_Data_oe=0.
- ADDR: lasts 1 cycle; ALEn=0, CEn=0, USB_Addr=cmd_addr.
- STROBE: RDn or WRn low for pSTROBE_CYCLES cycles.
- GAP: strobes high for pGAP_CYCLES cycles.
- END: lasts 1 cycle; CEn=1, ALEn=1, done=1.
REQ-023 When cmd_valid=1 and cmd_ready=1, the block shall latch cmd_write, cmd_addr and cmd_len and enter ADDR on the next edge.
REQ-024 While in IDLE, cmd_ready=1 and it drops on the cycle after acceptance.
REQ-025 CEn shall stay low from ADDR through the last GAP. ALEn shall return high after ADDR.
REQ-026 ADDR shall be followed by GAP. GAP goes to STROBE if bytes remain, otherwise to END. END goes to IDLE.
REQ-027 Write burst:
- On GAP-to-STROBE, wdata_ready=1 for exactly that cycle, and only if wdata_valid=1.
- The accepted byte drives USB_Data_out with USB_Data_oe=1 for the whole STROBE state and the following GAP.
REQ-028 Write underflow: if wdata_valid=0 at the end of GAP, the block shall stay in GAP with strobes high, indefinitely, until wdata_valid=1.
REQ-029 Read burst:
- USB_Data_oe=0 throughout.
- USB_Data_in shall be sampled on the last STROBE cycle.
- rdata and rdata_valid shall be presented on the next cycle, so the first byte appears pSTROBE_CYCLES+1 cycles after RDn falls.
REQ-030 A byte counter, 9 bits wide, counts from cmd_len down. A burst of cmd_len=255 shall issue exactly 256 strobes with no wrap to 0.
REQ-031 USB_Addr shall hold the latched address for the whole burst. The address does not auto-increment.
REQ-032 RDn and WRn shall never be low at the same time. Neither shall be low while ALEn=0.
REQ-033 cmd_valid during a busy burst shall be ignored, with cmd_ready=0. The command is accepted only once the block returns to IDLE.
REQ-034 Minimum burst duration is 1 + N*(pSTROBE_CYCLES+pGAP_CYCLES) + pGAP_CYCLES + 1 cycles, where N is the byte count.

Reset
REQ-035 While reset_n=0 at a clock edge, the following shall hold on the next edge:
- State = IDLE.
- USB_RDn, USB_WRn, USB_CEn and USB_ALEn = 1.
- USB_Data_oe = 0.
- USB_Addr and USB_Data_out = 0x00.
- cmd_ready = 1.
- wdata_ready, rdata_valid and done = 0.
- Byte counter = 0.
REQ-036 If reset occurs mid-burst, the burst is aborted. No done pulse is issued, and any partially read byte is discarded.

Verification
REQ-037 Single write: cmd addr=0x3A, len=0, write, wdata=0x5C valid -> ALEn low for 1 cycle with USB_Addr=0x3A; one WRn-low pulse of 2 cycles with USB_Data_out=0x5C; done asserted 5 cycles after ADDR.
REQ-038 Read burst: addr=0x10, len=3, USB_Data_in returning 0x01..0x04 per strobe -> four RDn pulses; four rdata_valid pulses with rdata=0x01, 0x02, 0x03, 0x04; USB_Data_oe=0 throughout; one done.
REQ-039 Write underflow: len=1, second wdata_valid withheld for 10 cycles -> the bus is idle-high in GAP for 10 cycles with CEn still low; resumes with a single WRn pulse.
REQ-040 Max burst: len=255 write with continuous wdata -> exactly 256 WRn falling edges; counter does not wrap; done once.
REQ-041 Reset mid-read: reset_n low during the 2nd STROBE of a len=3 read -> next cycle all strobes high and cmd_ready=1; no further rdata_valid; no done.
REQ-042 Busy command: cmd_valid held through a burst -> second command accepted only in the IDLE cycle after END; RDn/WRn never overlap (assertion).
